datapath_ctrl_seq: RTL and testbench
====================================

# datapath_ctrl_seq

- Hardwired control sequencer for the 32-bit bus datapath.
- Generates, cycle by cycle, the register/bus strobes that a bench otherwise drives by hand: PC/MAR/MDR/IR/Y/Z/HI/LO enables, one-hot general-register in/out selects, and the 5-bit ALU operation code.
- Fetches each instruction over the datapath's memory-read path, decodes it from the IR value the datapath returns, and sequences register-register ALU and shift operations, plus optionally MUL/DIV.

## Interface
Parameters:
- MEM_TIMEOUT, 15: maximum wait cycles for mem_rdy in T1 before a fault; range 1–255.
- NREGS, 16: number of general registers; sets the Rin/Rout width; fixed at 16 in this design.

Ports:
- clk  in  1  rising-edge clock.
- Clear  in  1  asynchronous, active-low reset.
- Run  in  1  level; high permits fetching the next instruction.
- mem_rdy  in  1  memory data valid on Mdatain during T1.
- IR  in  32  datapath IR contents; opcode [31:27], ra [26:23], rb [22:19], rc [18:15].
- PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhiout, LOin, HIin  out  1 each  datapath strobes.
- Rin  out  16  one-hot register write select.
- Rout  out  16  one-hot register bus-drive select.
- alu_op  out  5  ALU operation code.
- Busy  out  1  high in any state other than IDLE and FAULT.
- Done  out  1  one-cycle pulse on the final cycle of each instruction.
- Fault  out  1  sticky error flag; cleared only by Clear.

## Operation
Opcodes:
- Register-register: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shl, 00101 shr, 00110 shra, 00111 rol, 01000 ror.
- 01111 mul, 10000 div.
- Any other opcode is illegal.

States (Moore outputs; strobes not listed are 0):
- IDLE: no strobes. Go to T0 if Run=1.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin on the first T1 cycle only; Read, MDRin held every T1 cycle. Leave for T2 when mem_rdy=1. Go to FAULT after MEM_TIMEOUT cycles without mem_rdy.
- T2: MDRout, IRin. IR becomes valid from T3 onward.
- T3: Rout[rb], Yin. An illegal opcode goes to FAULT instead, with no strobes asserted.
- T4: Rout[rc], Zin, alu_op=opcode.
- T5, ALU ops: Zlowout, Rin[ra], Done.
- T5, mul/div: Zlowout, LOin.
- T6, mul/div only: Zhiout, HIin, Done.
- After Done: go to T0 if Run=1, otherwise IDLE.
- FAULT: all strobes 0, Fault=1. Held until Clear.

Decode and output rules:
- alu_op is 0 in every state except T4.
- Rin and Rout are always one-hot or all-zero; at most one bit of each is set.
- ra=0 is legal; R0 gets written normally.
- rb=rc is legal.
- The wait counter is 8 bits wide and resets on entry to T1.

## Timing
- Reset: while Clear=0, all outputs are 0, state is IDLE, and the counter is 0, asynchronously.
- Clear asserted mid-instruction aborts immediately. No partial strobes remain after Clear is released.
- Run is sampled only in IDLE and on the Done cycle. Dropping Run mid-instruction does not abort the instruction.
- ALU instruction latency: 6 cycles (T0–T5) plus the number of T1 wait cycles.
- Mul/div latency: 7 cycles plus the number of T1 wait cycles.
- Back-to-back instructions with Run=1 and mem_rdy=1 every cycle: T0 follows the Done cycle directly, so issue rate is one ALU instruction per 6 cycles.
- mem_rdy already high on the first T1 cycle gives zero wait cycles.
- mem_rdy arriving on the last allowed wait cycle (cycle count = MEM_TIMEOUT) succeeds; the fault occurs only on the following cycle.
- Done and Fault are never high together.

## Configuration
- MULDIV_EN defined: opcodes 01111 and 10000 sequence T5 (LO) and T6 (HI) as described above.
- MULDIV_EN undefined: opcodes 01111 and 10000 are illegal and go to FAULT at T3. LOin, HIin and Zhiout are tied to 0, and state T6 is not built.

## Test plan
- shr R2,R1,R3:
  - Stimulus: IR=0x29098000, mem_rdy=1, Run pulsed.
  - T3: Rout=0x0002 with Yin.
  - T4: Rout=0x0008, alu_op=5'b00101, Zin.
  - T5: Rin=0x0004 with Zlowout and Done; return to IDLE.
- Memory wait: mem_rdy held low for 3 cycles. T1 lasts 4 cycles and PCin pulses once. Total latency is 9 cycles.
- Timeout: MEM_TIMEOUT=4 with mem_rdy never asserted. Fault=1 on the 5th cycle after entering T1, Busy=0, all strobes 0.
- Illegal opcode 11111: FAULT entered at T3 with no Rout asserted. Clear low then high returns to IDLE with Fault=0.
- mul R4,R5 with MULDIV_EN defined: T5 asserts LOin, T6 asserts HIin, Done on T6, 7 cycles total. With MULDIV_EN undefined, Fault=1 at T3.
- Abort: Clear dropped during T4. All outputs 0 within the same cycle, no Rin pulse. Run=1 after release restarts at T0.

Source files
------------

// File: rtl/datapath_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : datapath_ctrl_seq
// Description : Hardwired control sequencer for the 32-bit bus datapath.
//               Fetches an instruction, decodes the IR the datapath returns
//               and sequences the register/bus strobes of register-register
//               ALU/shift operations.
//               Optional feature macro: MULDIV_EN (adds mul/div sequencing
//               with LO/HI write-back through state T6).
// Revision    : 1.0 - initial release
// ============================================================================
module datapath_ctrl_seq #(
  parameter int MEM_TIMEOUT = 15,
  parameter int NREGS       = 16
) (
  input  logic             clk,
  input  logic             Clear,
  input  logic             Run,
  input  logic             mem_rdy,
  input  logic [31:0]      IR,
  output logic             PCout,
  output logic             IncPC,
  output logic             PCin,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhiout,
  output logic             LOin,
  output logic             HIin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [4:0]       alu_op,
  output logic             Busy,
  output logic             Done,
  output logic             Fault
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FAULT = 4'd1,
    S_T0    = 4'd2,
    S_T1    = 4'd3,
    S_T2    = 4'd4,
    S_T3    = 4'd5,
    S_T4    = 4'd6,
    S_T5    = 4'd7
`ifdef MULDIV_EN
    ,
    S_T6    = 4'd8
`endif
  } state_t;

  // Last wait-counter value that may still see mem_rdy before faulting.
  localparam logic [7:0] C_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;

  logic [4:0]       w_opcode;
  logic [NREGS-1:0] w_ra_oh, w_rb_oh, w_rc_oh;
  logic             w_is_alu, w_is_md, w_legal;
  logic             unused_ir;

  assign w_opcode  = IR[31:27];
  assign w_ra_oh   = NREGS'(1) << IR[26:23];
  assign w_rb_oh   = NREGS'(1) << IR[22:19];
  assign w_rc_oh   = NREGS'(1) << IR[18:15];
  assign unused_ir = ^IR[14:0];

  // Opcode classification: 0..8 are ALU/shift ops, 15/16 are mul/div.
  assign w_is_alu = (w_opcode <= 5'd8);
`ifdef MULDIV_EN
  assign w_is_md  = (w_opcode == 5'd15) || (w_opcode == 5'd16);
`else
  assign w_is_md  = 1'b0;
`endif
  assign w_legal  = w_is_alu | w_is_md;

  // State and wait counter; Clear forces IDLE and a zero counter at once.
  always_ff @(posedge clk or negedge Clear) begin
    if (!Clear) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and Moore strobes decoded from the current state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    PCout   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    MARin   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    Zhiout  = 1'b0;
    LOin    = 1'b0;
    HIin    = 1'b0;
    Rin     = '0;
    Rout    = '0;
    alu_op  = 5'd0;
    Done    = 1'b0;
    Fault   = 1'b0;
    Busy    = (state_q != S_IDLE) && (state_q != S_FAULT);

    case (state_q)
      S_IDLE: begin
        if (Run) state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        cnt_d   = 8'd0;
        state_d = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // The incremented PC is written back exactly once per fetch.
        if (cnt_q == 8'd0) begin
          Zlowout = 1'b1;
          PCin    = 1'b1;
        end
        if (mem_rdy) begin
          state_d = S_T2;
        end else if (cnt_q == C_WAIT_LAST) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        // An illegal opcode emits nothing here and parks in FAULT.
        if (w_legal) begin
          Rout    = w_rb_oh;
          Yin     = 1'b1;
          state_d = S_T4;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: begin
        Rout    = w_rc_oh;
        Zin     = 1'b1;
        alu_op  = w_opcode;
        state_d = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
`ifdef MULDIV_EN
        if (w_is_md) begin
          LOin    = 1'b1;
          state_d = S_T6;
        end else begin
          Rin     = w_ra_oh;
          Done    = 1'b1;
          state_d = Run ? S_T0 : S_IDLE;
        end
`else
        Rin     = w_ra_oh;
        Done    = 1'b1;
        state_d = Run ? S_T0 : S_IDLE;
`endif
      end
`ifdef MULDIV_EN
      S_T6: begin
        Zhiout  = 1'b1;
        HIin    = 1'b1;
        Done    = 1'b1;
        state_d = Run ? S_T0 : S_IDLE;
      end
`endif
      S_FAULT: begin
        Fault = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_datapath_ctrl_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_datapath_ctrl_seq
// Description : Self-checking bench for datapath_ctrl_seq. Each instruction
//               is turned into an expected per-cycle list of strobe vectors
//               built from the instruction phase table, then compared cycle
//               by cycle against the DUT under random Run/mem_rdy/IR noise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datapath_ctrl_seq;

  localparam int C_TO = 4;

  typedef struct packed {
    logic        PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhiout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        Busy, Done, Fault;
  } outv_t;

  logic        clk = 1'b0;
  logic        Clear, Run, mem_rdy;
  logic [31:0] IR;
  logic        PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin;
  logic        Yin, Zin, Zlowout, Zhiout, LOin, HIin;
  logic [15:0] Rin, Rout;
  logic [4:0]  alu_op;
  logic        Busy, Done, Fault;

  int n_checks = 0;
  int n_fail   = 0;

  outv_t exp_q[$];
  bit    rdy_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  datapath_ctrl_seq #(.MEM_TIMEOUT(C_TO), .NREGS(16)) u_dut (
    .clk(clk), .Clear(Clear), .Run(Run), .mem_rdy(mem_rdy), .IR(IR),
    .PCout(PCout), .IncPC(IncPC), .PCin(PCin), .MARin(MARin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhiout(Zhiout), .LOin(LOin), .HIin(HIin),
    .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .Busy(Busy), .Done(Done), .Fault(Fault)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic outv_t observe();
    outv_t o;
    o = '{PCout, IncPC, PCin, MARin, Read, MDRin, MDRout, IRin,
          Yin, Zin, Zlowout, Zhiout, LOin, HIin, Rin, Rout, alu_op,
          Busy, Done, Fault};
    return o;
  endfunction

  task automatic cmp(input string tag, input outv_t exp);
    check(tag, {10'd0, observe()}, {10'd0, exp});
  endtask

  function automatic void push(input outv_t v, input bit r, input string t);
    exp_q.push_back(v);
    rdy_q.push_back(r);
    tag_q.push_back(t);
  endfunction

  // Expected cycle list for one instruction from T0 onwards; returns 1 when
  // the instruction ends in FAULT (last entry is then the FAULT vector).
  function automatic bit build(input logic [4:0] op, input logic [3:0] ra,
                               input logic [3:0] rb, input logic [3:0] rc,
                               input int waits);
    outv_t v, flt;
    bit    md, legal;
    int    n_t1;
    exp_q.delete(); rdy_q.delete(); tag_q.delete();
`ifdef MULDIV_EN
    md = (op == 5'd15) || (op == 5'd16);
`else
    md = 1'b0;
`endif
    legal = (op <= 5'd8) || md;
    flt = '0; flt.Fault = 1'b1;

    v = '0; v.Busy = 1; v.PCout = 1; v.MARin = 1; v.IncPC = 1; v.Zin = 1;
    push(v, 1'($urandom), "T0");

    n_t1 = (waits < C_TO) ? waits + 1 : C_TO;
    for (int j = 0; j < n_t1; j++) begin
      v = '0; v.Busy = 1; v.Read = 1; v.MDRin = 1;
      if (j == 0) begin v.Zlowout = 1; v.PCin = 1; end
      push(v, (j >= waits), "T1");
    end
    if (waits >= C_TO) begin
      push(flt, 1'($urandom), "FAULT_timeout");
      return 1'b1;
    end

    v = '0; v.Busy = 1; v.MDRout = 1; v.IRin = 1;
    push(v, 1'($urandom), "T2");

    v = '0; v.Busy = 1;
    if (!legal) begin
      push(v, 1'($urandom), "T3_illegal");
      push(flt, 1'($urandom), "FAULT_illegal");
      return 1'b1;
    end
    v.Rout = 16'h1 << rb; v.Yin = 1;
    push(v, 1'($urandom), "T3");

    v = '0; v.Busy = 1; v.Rout = 16'h1 << rc; v.Zin = 1; v.alu_op = op;
    push(v, 1'($urandom), "T4");

    v = '0; v.Busy = 1; v.Zlowout = 1;
    if (md) begin
      v.LOin = 1;
      push(v, 1'($urandom), "T5_lo");
      v = '0; v.Busy = 1; v.Zhiout = 1; v.HIin = 1; v.Done = 1;
      push(v, 1'($urandom), "T6_hi");
    end else begin
      v.Rin = 16'h1 << ra; v.Done = 1;
      push(v, 1'($urandom), "T5");
    end
    return 1'b0;
  endfunction

  // Runs one instruction. in_t0: DUT already sits in T0. abort_at: cycle
  // index at which Clear is pulsed (-1 for none). ends_t0: DUT in T0 on exit.
  task automatic run_instr(input logic [4:0] op, input logic [3:0] ra,
                           input logic [3:0] rb, input logic [3:0] rc,
                           input int waits, input bit next_run, input bit in_t0,
                           input int abort_at, output bit ends_t0);
    bit    flt;
    outv_t z;
    z   = '0;
    flt = build(op, ra, rb, rc, waits);
    IR  = {op, ra, rb, rc, 15'($urandom)};
    if (!in_t0) begin
      Run = 1'b1;
      @(posedge clk); #1;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      cmp(tag_q[i], exp_q[i]);
      mem_rdy = rdy_q[i];
      Run     = (i == exp_q.size() - 1) ? next_run : 1'($urandom);
      if (i == abort_at) begin
        #2 Clear = 1'b0;
        #1 cmp("abort_async", z);
        @(posedge clk); #1 cmp("abort_held", z);
        @(negedge clk); Clear = 1'b1; Run = 1'b1;
        @(posedge clk); #1 cmp("restart_T0", exp_q[0]);
        ends_t0 = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    if (flt) begin
      Run = 1'b1; mem_rdy = 1'b1;
      repeat (2) begin
        cmp("FAULT_hold", exp_q[exp_q.size() - 1]);
        @(posedge clk); #1;
      end
      #2 Clear = 1'b0;
      #1 cmp("clear_async", z);
      @(negedge clk); Clear = 1'b1; Run = 1'b0;
      @(posedge clk); #1 cmp("IDLE_after_clear", z);
      ends_t0 = 1'b0;
    end else if (next_run) begin
      ends_t0 = 1'b1;
    end else begin
      cmp("IDLE", z);
      ends_t0 = 1'b0;
    end
  endtask

  initial begin
    bit         c;
    outv_t      z;
    logic [4:0] op;
    int         sel;
    z = '0;
    Clear = 1'b1; Run = 1'b0; mem_rdy = 1'b0; IR = 32'd0;

    #1 Clear = 1'b0;
    #2 cmp("reset_async", z);
    Run = 1'b1; mem_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1 cmp("reset_held", z);
    @(negedge clk); Clear = 1'b1; Run = 1'b0;
    @(posedge clk); #1 cmp("IDLE_after_reset", z);

    // shr R2,R1,R3 (IR 0x29098000), no memory wait.
    run_instr(5'd5, 4'd2, 4'd1, 4'd3, 0, 1'b0, 1'b0, -1, c);
    // Three wait cycles, then rdy on the last allowed wait cycle.
    run_instr(5'd0, 4'd1, 4'd2, 4'd3, 3, 1'b0, 1'b0, -1, c);
    run_instr(5'd1, 4'd6, 4'd7, 4'd8, C_TO - 1, 1'b0, 1'b0, -1, c);
    // Timeout: mem_rdy never arrives.
    run_instr(5'd1, 4'd1, 4'd2, 4'd3, C_TO, 1'b0, 1'b0, -1, c);
    // Illegal opcode.
    run_instr(5'd31, 4'd1, 4'd2, 4'd3, 0, 1'b0, 1'b0, -1, c);
    // mul R4,R5 and div.
    run_instr(5'd15, 4'd4, 4'd4, 4'd5, 0, 1'b0, 1'b0, -1, c);
    run_instr(5'd16, 4'd9, 4'd10, 4'd11, 1, 1'b0, 1'b0, -1, c);
    // ra=0, rb=rc, back-to-back issue.
    run_instr(5'd2, 4'd0, 4'd7, 4'd7, 0, 1'b1, 1'b0, -1, c);
    run_instr(5'd8, 4'd15, 4'd15, 4'd0, 0, 1'b0, c, -1, c);
    // Abort during T4, then restart from T0.
    run_instr(5'd0, 4'd3, 4'd4, 4'd5, 0, 1'b0, 1'b0, 4, c);
    run_instr(5'd7, 4'd12, 4'd13, 4'd14, 0, 1'b0, c, -1, c);

    // Randomised instruction stream.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 11);
      if (sel <= 8)       op = 5'(sel);
      else if (sel == 9)  op = 5'd15;
      else if (sel == 10) op = 5'd16;
      else                op = 5'($urandom_range(17, 31));
      run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, C_TO), 1'($urandom), c, -1, c);
    end
    if (c) begin
      // Drain a final instruction so the run ends in IDLE.
      run_instr(5'd0, 4'd1, 4'd1, 4'd1, 0, 1'b0, c, -1, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
